// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory, PC sequencing, stall, branch redirect
// with a one-cycle squash bubble, and halt on a terminating instruction word.
module instr_fetch #(
  parameter int          IW        = 10,
  parameter int          AW        = 8,
  parameter logic [IW-1:0] HALT_WORD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_adr,
  input  logic [IW-1:0] prog_data,
  input  logic          run,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] pc_out,
  output logic          instr_valid,
  output logic          halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          mem_we;
  logic [IW-1:0] mem_rd;

  assign mem_rd = mem[pc_q];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        // Program loading is only safe while nothing is being fetched.
        mem_we  = prog_we;
        valid_d = 1'b0;
        if (run) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (branch_taken && valid_q) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (mem_rd == HALT_WORD) begin
          // Halt word is swallowed; the last real instruction stays on the outputs.
          state_d  = S_HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else begin
          instr_d  = mem_rd;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Memory survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_adr] <= prog_data;
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected (instr, pc) pairs are queued as stimulus
// is applied and popped whenever the fetch stage presents a valid instruction.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [7:0] prog_adr;
  logic [9:0] prog_data;
  logic       run;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [9:0] instr_out;
  logic [7:0] pc_out;
  logic       instr_valid;
  logic       halted;

  int n_total = 0;
  int n_pass  = 0;
  logic [17:0] exp_q[$];

  instr_fetch #(.IW(10), .AW(8), .HALT_WORD(10'h000)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_adr(prog_adr),
    .prog_data(prog_data), .run(run), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [9:0] i, input logic [7:0] p);
    exp_q.push_back({i, p});
  endtask

  // One clock; sample just after the edge and score any valid output.
  task automatic cyc(input string tag);
    logic [17:0] e;
    @(posedge clk);
    #1;
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_valid"}, {14'h0, instr_out, pc_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_out"}, {14'h0, instr_out, pc_out}, {14'h0, e});
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [9:0] d);
    prog_we = 1'b1; prog_adr = a; prog_data = d;
    cyc("wr");
    prog_we = 1'b0;
  endtask

  task automatic start(input string tag);
    run = 1'b1;
    cyc(tag);
    run = 1'b0;
    chk({tag, "_bubble_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_halted_clr"}, {31'h0, halted}, 32'h0);
  endtask

  task automatic expect_halt(input string tag);
    cyc(tag);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h1);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_drained"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_adr = '0; prog_data = '0;
    run = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc", {24'h0, pc_out}, 32'h0);
    chk("rst_instr", {22'h0, instr_out}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    reset = 1'b0;

    wr(8'h00, 10'h101); wr(8'h01, 10'h202); wr(8'h02, 10'h303); wr(8'h03, 10'h000);
    wr(8'h80, 10'h1C0); wr(8'h81, 10'h000);

    // Straight-line program up to the halt word.
    push(10'h101, 8'h00); push(10'h202, 8'h01); push(10'h303, 8'h02);
    start("basic");
    cyc("basic"); cyc("basic"); cyc("basic");
    expect_halt("basic_end");

    // Stall holds 0x202/1; a branch during the post-run bubble is ignored.
    push(10'h101, 8'h00);
    repeat (4) push(10'h202, 8'h01);
    push(10'h303, 8'h02);
    start("stall");
    branch_taken = 1'b1; branch_target = 8'h80;
    cyc("stall");
    branch_taken = 1'b0;
    cyc("stall");
    stall = 1'b1;
    cyc("stall"); cyc("stall"); cyc("stall");
    stall = 1'b0;
    cyc("stall");
    expect_halt("stall_end");

    // Branch while 0x202/1 is presented: one bubble, then the target.
    push(10'h101, 8'h00); push(10'h202, 8'h01); push(10'h1C0, 8'h80);
    start("br");
    cyc("br"); cyc("br");
    branch_taken = 1'b1; branch_target = 8'h80;
    cyc("br");
    branch_taken = 1'b0;
    chk("br_bubble", {31'h0, instr_valid}, 32'h0);
    cyc("br");
    expect_halt("br_end");

    // Program write during fetch must be dropped.
    push(10'h101, 8'h00); push(10'h202, 8'h01); push(10'h303, 8'h02);
    start("we");
    cyc("we");
    prog_we = 1'b1; prog_adr = 8'h02; prog_data = 10'h0AA;
    cyc("we");
    prog_we = 1'b0;
    cyc("we");
    expect_halt("we_end");
    push(10'h101, 8'h00); push(10'h202, 8'h01); push(10'h303, 8'h02);
    start("we2");
    cyc("we2"); cyc("we2"); cyc("we2");
    expect_halt("we2_end");

    // Asynchronous reset mid-run, then replay from address 0.
    push(10'h101, 8'h00); push(10'h202, 8'h01);
    start("rst");
    cyc("rst"); cyc("rst");
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mid_pc", {24'h0, pc_out}, 32'h0);
    chk("rst_mid_halted", {31'h0, halted}, 32'h0);
    #2 reset = 1'b0;
    push(10'h101, 8'h00); push(10'h202, 8'h01); push(10'h303, 8'h02);
    start("replay");
    cyc("replay"); cyc("replay"); cyc("replay");
    expect_halt("replay_end");

    // PC wrap from 0xFF to 0x00.
    wr(8'h00, 10'h155); wr(8'hFF, 10'h3FF); wr(8'h01, 10'h000);
    push(10'h155, 8'h00); push(10'h3FF, 8'hFF); push(10'h155, 8'h00);
    start("wrap");
    cyc("wrap");
    branch_taken = 1'b1; branch_target = 8'hFF;
    cyc("wrap");
    branch_taken = 1'b0;
    chk("wrap_bubble", {31'h0, instr_valid}, 32'h0);
    cyc("wrap"); cyc("wrap");
    expect_halt("wrap_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
